// File: rtl/life_grid_engine.sv
// Conway's Game of Life engine (B3/S23) over a ROWS x COLS register grid.
// Evolves one full generation per clock; halts on still-life, extinction or generation limit.
module life_grid_engine #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int GEN_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [ROWS*COLS-1:0]   seed,
    input  logic                   run,
    input  logic                   step,
    input  logic                   wrap,
    input  logic [GEN_W-1:0]       max_gens,
    output logic [ROWS*COLS-1:0]   grid,
    output logic [GEN_W-1:0]       gen_count,
    output logic                   busy,
    output logic                   stable,
    output logic                   extinct,
    output logic                   done
);
    localparam int N = ROWS * COLS;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [N-1:0]     grid_q, grid_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic             stable_q, stable_d;
    logic             extinct_q, extinct_d;

    logic [N-1:0]     next_grid;
    logic [GEN_W-1:0] gen_inc;
    logic             next_same, next_zero, limit_hit;

    // Per-cell neighbour sum; off-grid neighbours are masked unless wrapping.
    genvar gi, gj;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row
            for (gj = 0; gj < COLS; gj++) begin : g_col
                localparam int   RU  = (gi + ROWS - 1) % ROWS;
                localparam int   RD  = (gi + 1) % ROWS;
                localparam int   CL  = (gj + COLS - 1) % COLS;
                localparam int   CR  = (gj + 1) % COLS;
                localparam logic TOP = (gi == 0);
                localparam logic BOT = (gi == ROWS - 1);
                localparam logic LFT = (gj == 0);
                localparam logic RGT = (gj == COLS - 1);

                logic       ok_u, ok_d, ok_l, ok_r;
                logic [7:0] nb;
                logic [3:0] cnt;

                assign ok_u = wrap | ~TOP;
                assign ok_d = wrap | ~BOT;
                assign ok_l = wrap | ~LFT;
                assign ok_r = wrap | ~RGT;

                assign nb[0] = grid_q[RU*COLS + CL] & ok_u & ok_l;
                assign nb[1] = grid_q[RU*COLS + gj] & ok_u;
                assign nb[2] = grid_q[RU*COLS + CR] & ok_u & ok_r;
                assign nb[3] = grid_q[gi*COLS + CL] & ok_l;
                assign nb[4] = grid_q[gi*COLS + CR] & ok_r;
                assign nb[5] = grid_q[RD*COLS + CL] & ok_d & ok_l;
                assign nb[6] = grid_q[RD*COLS + gj] & ok_d;
                assign nb[7] = grid_q[RD*COLS + CR] & ok_d & ok_r;

                assign cnt = {3'b000, nb[0]} + {3'b000, nb[1]} + {3'b000, nb[2]}
                           + {3'b000, nb[3]} + {3'b000, nb[4]} + {3'b000, nb[5]}
                           + {3'b000, nb[6]} + {3'b000, nb[7]};

                assign next_grid[gi*COLS + gj] = (cnt == 4'd3)
                                               | (grid_q[gi*COLS + gj] & (cnt == 4'd2));
            end
        end
    endgenerate

    assign gen_inc   = gen_q + 1'b1;
    assign next_same = (next_grid == grid_q);
    assign next_zero = (next_grid == '0);
    // Limit compares the pre-increment count + 1 so max_gens=1 stops after one generation.
    assign limit_hit = (max_gens != '0) && (gen_inc == max_gens);

    always_comb begin
        state_d   = state_q;
        grid_d    = grid_q;
        gen_d     = gen_q;
        stable_d  = stable_q;
        extinct_d = extinct_q;

        if (load) begin
            grid_d    = seed;
            gen_d     = '0;
            stable_d  = 1'b0;
            extinct_d = 1'b0;
            state_d   = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run) begin
                        state_d = ST_RUN;
                    end else if (step) begin
                        grid_d    = next_grid;
                        gen_d     = (&gen_q) ? gen_q : gen_inc;
                        stable_d  = next_same;
                        extinct_d = next_zero;
                    end
                end
                ST_RUN: begin
                    if (!run) begin
                        state_d = ST_IDLE;
                    end else begin
                        grid_d    = next_grid;
                        gen_d     = (&gen_q) ? gen_q : gen_inc;
                        stable_d  = next_same;
                        extinct_d = next_zero;
                        if (next_same || next_zero || limit_hit) begin
                            state_d = ST_HALT;
                        end
                    end
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            grid_q    <= '0;
            gen_q     <= '0;
            stable_q  <= 1'b0;
            extinct_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grid_q    <= grid_d;
            gen_q     <= gen_d;
            stable_q  <= stable_d;
            extinct_q <= extinct_d;
        end
    end

    assign grid      = grid_q;
    assign gen_count = gen_q;
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_HALT);
    assign stable    = stable_q;
    assign extinct   = extinct_q;

endmodule

// File: tb/tb_life_grid_engine.sv
// Bench for life_grid_engine: directed scenarios plus randomized runs against a
// cell-by-cell Game of Life reference model.
module tb_life_grid_engine;
    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int GEN_W = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              load = 1'b0;
    logic [63:0]       seed = '0;
    logic              run = 1'b0;
    logic              step = 1'b0;
    logic              wrap = 1'b0;
    logic [GEN_W-1:0]  max_gens = '0;
    logic [63:0]       grid;
    logic [GEN_W-1:0]  gen_count;
    logic              busy, stable, extinct, done;

    int checks = 0;
    int passed = 0;

    life_grid_engine #(.ROWS(ROWS), .COLS(COLS), .GEN_W(GEN_W)) dut (
        .clk(clk), .reset(reset), .load(load), .seed(seed), .run(run), .step(step),
        .wrap(wrap), .max_gens(max_gens), .grid(grid), .gen_count(gen_count),
        .busy(busy), .stable(stable), .extinct(extinct), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [63:0] bits(input int a, input int b, input int c,
                                         input int d = -1, input int e = -1);
        logic [63:0] v = '0;
        v[a] = 1'b1; v[b] = 1'b1; v[c] = 1'b1;
        if (d >= 0) v[d] = 1'b1;
        if (e >= 0) v[e] = 1'b1;
        return v;
    endfunction

    // Reference: count live neighbours of every cell straight from the B3/S23 rule.
    function automatic logic [63:0] life_next(input logic [63:0] g, input bit w);
        logic [63:0] nx = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                int n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int rr = r + dr;
                        int cc = c + dc;
                        if (dr == 0 && dc == 0) continue;
                        if (w) begin
                            rr = (rr + ROWS) % ROWS;
                            cc = (cc + COLS) % COLS;
                        end else if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) begin
                            continue;
                        end
                        n += int'(g[rr*COLS + cc]);
                    end
                end
                nx[r*COLS + c] = (n == 3) || (g[r*COLS + c] && n == 2);
            end
        end
        return nx;
    endfunction

    task automatic do_load(input logic [63:0] s);
        seed = s; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        check(tag, {63'd0, done}, 64'd1);
    endtask

    logic [63:0] blinker_h, blinker_v, block, glider, ref_g, ref_prev;
    int          ref_k;
    bit          ref_w;

    initial begin
        blinker_h = bits(26, 27, 28);
        blinker_v = bits(19, 27, 35);
        block     = bits(0, 1, 8, 9);
        glider    = bits(1, 10, 16, 17, 18);

        // Reset state
        tick(); tick();
        check("reset_grid", grid, 64'd0);
        check("reset_flags", {58'd0, busy, stable, extinct, done}, 64'd0);
        reset = 1'b0;
        tick();

        // Blinker by single step, no wrap
        wrap = 1'b0;
        do_load(blinker_h);
        check("blink_load", grid, blinker_h);
        step = 1'b1; tick(); step = 1'b0;
        check("blink_step1", grid, blinker_v);
        check("blink_gen1", 64'(gen_count), 64'd1);
        check("blink_idle", {62'd0, busy, done}, 64'd0);
        step = 1'b1; tick(); step = 1'b0;
        check("blink_step2", grid, blinker_h);
        check("blink_stable", {63'd0, stable}, 64'd0);

        // Still life halts after one generation
        do_load(block);
        run = 1'b1; tick();
        check("block_busy", {63'd0, busy}, 64'd1);
        check("block_noevo", 64'(gen_count), 64'd0);
        tick();
        run = 1'b0;
        check("block_done", {60'd0, busy, stable, extinct, done}, 64'b0101);
        check("block_gen", 64'(gen_count), 64'd1);
        check("block_grid", grid, block);

        // Extinction
        wrap = 1'b1;
        do_load(64'd1 << 63);
        check("ext_cleared", {62'd0, stable, done}, 64'd0);
        run = 1'b1; tick(); tick();
        check("ext_flags", {60'd0, busy, stable, extinct, done}, 64'b0011);
        check("ext_grid", grid, 64'd0);
        check("ext_gen", 64'(gen_count), 64'd1);
        tick();
        check("ext_hold", 64'(gen_count), 64'd1);
        run = 1'b0;

        // Toroidal glider returns after 32 generations
        max_gens = 16'd32;
        do_load(glider);
        run = 1'b1; tick();
        wait_done(40, "glider_done");
        run = 1'b0;
        check("glider_gen", 64'(gen_count), 64'd32);
        check("glider_grid", grid, glider);
        check("glider_stable", {63'd0, stable}, 64'd0);

        // Limit and pause
        wrap = 1'b0; max_gens = 16'd5;
        do_load(blinker_h);
        run = 1'b1; tick(); tick(); tick();
        run = 1'b0; tick();
        check("pause_gen", 64'(gen_count), 64'd2);
        check("pause_idle", {62'd0, busy, done}, 64'd0);
        tick();
        check("pause_hold", grid, blinker_h);
        run = 1'b1; tick();
        wait_done(10, "limit_done");
        check("limit_gen", 64'(gen_count), 64'd5);
        check("limit_grid", grid, blinker_v);
        step = 1'b1; tick(); step = 1'b0;
        check("halt_ignores_step", grid, blinker_v);

        // Priority: load beats run and step
        max_gens = '0;
        do_load(blinker_h);
        tick(); tick(); tick();
        load = 1'b1; step = 1'b1; seed = glider;
        tick();
        load = 1'b0; step = 1'b0;
        check("prio_grid", grid, glider);
        check("prio_gen", 64'(gen_count), 64'd0);
        check("prio_state", {62'd0, busy, done}, 64'd0);
        tick(); tick();
        check("prio_run", grid, life_next(glider, 1'b0));
        #3 reset = 1'b1;
        #1;
        check("async_grid", grid, 64'd0);
        check("async_out", {44'd0, gen_count, busy, stable, extinct, done}, 64'd0);
        run = 1'b0;
        tick();
        reset = 1'b0;

        // Randomized single steps with random wrap per generation
        ref_g = {$urandom, $urandom};
        do_load(ref_g);
        for (int i = 0; i < 12; i++) begin
            ref_w = 1'($urandom_range(0, 1));
            wrap = ref_w;
            ref_g = life_next(ref_g, ref_w);
            step = 1'b1; tick(); step = 1'b0;
            check($sformatf("rstep%0d", i), grid, ref_g);
            check($sformatf("rstep%0d_gen", i), 64'(gen_count), 64'(i + 1));
        end

        // Randomized free runs: model predicts halting generation and flags
        for (int t = 0; t < 10; t++) begin
            logic [63:0] s;
            bit st, ex;
            int mx;
            s = {$urandom, $urandom} & {$urandom, $urandom};
            ref_w = 1'($urandom_range(0, 1));
            mx = $urandom_range(1, 12);
            ref_g = s; ref_k = 0;
            do begin
                ref_prev = ref_g;
                ref_g = life_next(ref_prev, ref_w);
                ref_k++;
                st = (ref_g == ref_prev);
                ex = (ref_g == 64'd0);
            end while (!(st || ex || ref_k == mx));
            wrap = ref_w; max_gens = 16'(mx);
            do_load(s);
            run = 1'b1; tick();
            wait_done(20, $sformatf("rrun%0d_done", t));
            run = 1'b0;
            check($sformatf("rrun%0d_grid", t), grid, ref_g);
            check($sformatf("rrun%0d_gen", t), 64'(gen_count), 64'(ref_k));
            check($sformatf("rrun%0d_flags", t), {62'd0, stable, extinct}, {62'd0, st, ex});
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
